// File: rtl/stdp_pkg.sv
// Shared types and helpers for the STDP update engine.
//   state_e      : service FSM states
//   kind_e       : pairing kind (LTP = pre before post, LTD = post before pre)
//   sat_add/sub  : saturating weight arithmetic, one bit wider than SAT_W internally
//   *_DEF        : default amplitudes, decay and pairing window
package stdp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEL,
        ST_RD,
        ST_CALC,
        ST_WR
    } state_e;

    typedef enum logic {
        KIND_LTP = 1'b0,
        KIND_LTD = 1'b1
    } kind_e;

    localparam int A_PLUS_DEF   = 16;
    localparam int A_MINUS_DEF  = 12;
    localparam int TAU_LOG2_DEF = 2;
    localparam int WIN_DEF      = 15;

    // Widest weight the helpers support; callers zero-extend narrower weights.
    localparam int SAT_W = 16;

    function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] a,
                                                 input logic [SAT_W-1:0] b,
                                                 input logic [SAT_W-1:0] max_v);
        logic [SAT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, max_v}) begin
            return max_v;
        end
        return sum[SAT_W-1:0];
    endfunction

    function automatic logic [SAT_W-1:0] sat_sub(input logic [SAT_W-1:0] a,
                                                 input logic [SAT_W-1:0] b);
        if (b > a) begin
            return '0;
        end
        return a - b;
    endfunction

endpackage

// File: rtl/stdp_delta_lut.sv
// Shift-decay weight delta lookup (combinational).
//   kind : pairing kind (KIND_LTP / KIND_LTD)
//   dt   : spike distance in ticks
//   dw   : amplitude >> (dt >> TAU_LOG2), zero once the shift empties the value
module stdp_delta_lut
    import stdp_pkg::*;
#(
    parameter int A_PLUS   = A_PLUS_DEF,
    parameter int A_MINUS  = A_MINUS_DEF,
    parameter int TAU_LOG2 = TAU_LOG2_DEF,
    parameter int W_WIDTH  = 8,
    parameter int T_WIDTH  = 5
) (
    input  logic               kind,
    input  logic [T_WIDTH-1:0] dt,
    output logic [W_WIDTH-1:0] dw
);

    logic [31:0] amp;
    logic [31:0] sh;

    always_comb begin
        amp = (kind == KIND_LTD) ? 32'(A_MINUS) : 32'(A_PLUS);
        sh  = 32'(dt) >> TAU_LOG2;
        if (sh >= 32'(W_WIDTH + 8)) begin
            dw = '0;
        end else begin
            dw = W_WIDTH'(amp >> sh);
        end
    end

endmodule

// File: rtl/stdp_update_engine.sv
// Pair-based STDP update engine for one neuron with N_PRE synapses.
// Tracks spike ages, queues LTP/LTD pairings per synapse and applies a
// saturating read-modify-write to the external weight memory.
//   clk, rst (async, active-low), kill (sync flush)
//   tick, pre_spike, post_spike : spike inputs, sampled only when tick=1
//   neuron_number               : upper memory address bits
//   mem_*                       : req/ack weight memory port
//   o_wait                      : busy (pending pairings or FSM active)
//   upd_valid/upd_idx/updated_weight : write-completion report
//   overrun                     : sticky, unserviced pairing was overwritten
//
// state   | meaning
// IDLE    | nothing in service
// SEL     | take lowest pending synapse, latch kind/dt/address
// RD      | read weight, wait for ack
// CALC    | compute saturated new weight
// WR      | write weight, wait for ack, report update
module stdp_update_engine
    import stdp_pkg::*;
#(
    parameter int N_PRE    = 8,
    parameter int W_WIDTH  = 8,
    parameter int T_WIDTH  = 5,
    parameter int NID_W    = 7,
    parameter int WIN      = WIN_DEF,
    parameter int A_PLUS   = A_PLUS_DEF,
    parameter int A_MINUS  = A_MINUS_DEF,
    parameter int TAU_LOG2 = TAU_LOG2_DEF,
    localparam int IDX_W   = $clog2(N_PRE)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   kill,
    input  logic                   tick,
    input  logic [N_PRE-1:0]       pre_spike,
    input  logic                   post_spike,
    input  logic [NID_W-1:0]       neuron_number,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [NID_W+IDX_W-1:0] mem_addr,
    output logic [W_WIDTH-1:0]     mem_wdata,
    input  logic [W_WIDTH-1:0]     mem_rdata,
    input  logic                   mem_ack,
    output logic                   o_wait,
    output logic                   upd_valid,
    output logic [IDX_W-1:0]       upd_idx,
    output logic [W_WIDTH-1:0]     updated_weight,
    output logic                   overrun
);

    localparam logic [T_WIDTH-1:0] WIN_T = T_WIDTH'(WIN);
    localparam logic [W_WIDTH-1:0] W_MAX = '1;

    state_e                        state_q, state_d;
    logic [N_PRE-1:0][T_WIDTH-1:0] pre_age_q, pre_age_d;
    logic [T_WIDTH-1:0]            post_age_q, post_age_d;
    logic [N_PRE-1:0]              pend_q, pend_d;
    logic [N_PRE-1:0]              pkind_q, pkind_d;    // 1 = LTD
    logic [N_PRE-1:0][T_WIDTH-1:0] pdt_q, pdt_d;
    kind_e                         srv_kind_q, srv_kind_d;
    logic [T_WIDTH-1:0]            srv_dt_q, srv_dt_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic [NID_W+IDX_W-1:0]        addr_q, addr_d;
    logic [W_WIDTH-1:0]            rdata_q, rdata_d;
    logic [W_WIDTH-1:0]            wdata_q, wdata_d;
    logic [W_WIDTH-1:0]            upd_w_q, upd_w_d;
    logic [IDX_W-1:0]              upd_idx_q, upd_idx_d;
    logic                          upd_valid_q, upd_valid_d;
    logic                          overrun_q, overrun_d;

    logic [W_WIDTH-1:0] dw;
    logic               sel_hit;
    logic [IDX_W-1:0]   sel_idx;
    logic [T_WIDTH-1:0] post_inc;
    logic [T_WIDTH-1:0] pre_dt;
    logic               ltp_hit;
    logic               ltd_hit;

    function automatic logic [T_WIDTH-1:0] age_inc(input logic [T_WIDTH-1:0] a);
        return (a == '1) ? a : a + 1'b1;
    endfunction

    stdp_delta_lut #(
        .A_PLUS   (A_PLUS),
        .A_MINUS  (A_MINUS),
        .TAU_LOG2 (TAU_LOG2),
        .W_WIDTH  (W_WIDTH),
        .T_WIDTH  (T_WIDTH)
    ) u_lut (
        .kind (srv_kind_q),
        .dt   (srv_dt_q),
        .dw   (dw)
    );

    always_comb begin
        state_d     = state_q;
        pre_age_d   = pre_age_q;
        post_age_d  = post_age_q;
        pend_d      = pend_q;
        pkind_d     = pkind_q;
        pdt_d       = pdt_q;
        srv_kind_d  = srv_kind_q;
        srv_dt_d    = srv_dt_q;
        idx_d       = idx_q;
        addr_d      = addr_q;
        rdata_d     = rdata_q;
        wdata_d     = wdata_q;
        upd_w_d     = upd_w_q;
        upd_idx_d   = upd_idx_q;
        upd_valid_d = 1'b0;
        overrun_d   = overrun_q;
        sel_hit     = 1'b0;
        sel_idx     = '0;
        post_inc    = age_inc(post_age_q);
        pre_dt      = '0;
        ltp_hit     = 1'b0;
        ltd_hit     = 1'b0;

        for (int i = 0; i < N_PRE; i++) begin
            if (!sel_hit && pend_q[i]) begin
                sel_hit = 1'b1;
                sel_idx = IDX_W'(i);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (|pend_q) begin
                    state_d = ST_SEL;
                end
            end
            ST_SEL: begin
                if (sel_hit) begin
                    pend_d[sel_idx] = 1'b0;
                    idx_d           = sel_idx;
                    addr_d          = {neuron_number, sel_idx};
                    srv_kind_d      = pkind_q[sel_idx] ? KIND_LTD : KIND_LTP;
                    srv_dt_d        = pdt_q[sel_idx];
                    state_d         = ST_RD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD: begin
                if (mem_ack) begin
                    rdata_d = mem_rdata;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                if (srv_kind_q == KIND_LTP) begin
                    wdata_d = W_WIDTH'(sat_add(SAT_W'(rdata_q), SAT_W'(dw), SAT_W'(W_MAX)));
                end else begin
                    wdata_d = W_WIDTH'(sat_sub(SAT_W'(rdata_q), SAT_W'(dw)));
                end
                state_d = ST_WR;
            end
            ST_WR: begin
                if (mem_ack) begin
                    upd_valid_d = 1'b1;
                    upd_idx_d   = idx_q;
                    upd_w_d     = wdata_q;
                    state_d     = (|pend_q) ? ST_SEL : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Pairing capture runs after service selection so that an event on the
        // synapse being selected this cycle re-arms its pending bit.
        if (tick) begin
            for (int i = 0; i < N_PRE; i++) begin
                pre_dt  = pre_spike[i] ? '0 : age_inc(pre_age_q[i]);
                ltp_hit = post_spike && (pre_dt <= WIN_T);
                ltd_hit = pre_spike[i] && !post_spike && (post_inc <= WIN_T);
                if (ltp_hit || ltd_hit) begin
                    // A bit leaving for service this cycle is not an overrun.
                    if (pend_q[i] && !(state_q == ST_SEL && sel_idx == IDX_W'(i))) begin
                        overrun_d = 1'b1;
                    end
                    pend_d[i]  = 1'b1;
                    pkind_d[i] = ltd_hit;
                    pdt_d[i]   = ltp_hit ? pre_dt : post_inc;
                end
                pre_age_d[i] = pre_spike[i] ? '0 : age_inc(pre_age_q[i]);
            end
            post_age_d = post_spike ? '0 : post_inc;
        end

        if (kill) begin
            state_d     = ST_IDLE;
            pend_d      = '0;
            overrun_d   = 1'b0;
            pre_age_d   = '1;
            post_age_d  = '1;
            upd_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            pre_age_q   <= '1;
            post_age_q  <= '1;
            pend_q      <= '0;
            pkind_q     <= '0;
            pdt_q       <= '0;
            srv_kind_q  <= KIND_LTP;
            srv_dt_q    <= '0;
            idx_q       <= '0;
            addr_q      <= '0;
            rdata_q     <= '0;
            wdata_q     <= '0;
            upd_w_q     <= '0;
            upd_idx_q   <= '0;
            upd_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pre_age_q   <= pre_age_d;
            post_age_q  <= post_age_d;
            pend_q      <= pend_d;
            pkind_q     <= pkind_d;
            pdt_q       <= pdt_d;
            srv_kind_q  <= srv_kind_d;
            srv_dt_q    <= srv_dt_d;
            idx_q       <= idx_d;
            addr_q      <= addr_d;
            rdata_q     <= rdata_d;
            wdata_q     <= wdata_d;
            upd_w_q     <= upd_w_d;
            upd_idx_q   <= upd_idx_d;
            upd_valid_q <= upd_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign mem_req        = (state_q == ST_RD) || (state_q == ST_WR);
    assign mem_we         = (state_q == ST_WR);
    assign mem_addr       = addr_q;
    assign mem_wdata      = wdata_q;
    assign o_wait         = (|pend_q) || (state_q != ST_IDLE);
    assign upd_valid      = upd_valid_q;
    assign upd_idx        = upd_idx_q;
    assign updated_weight = upd_w_q;
    assign overrun        = overrun_q;

endmodule

// File: tb/tb_stdp_update_engine.sv
module tb_stdp_update_engine;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       kill = 1'b0;
    logic       tick = 1'b0;
    logic [7:0] pre_spike = '0;
    logic       post_spike = 1'b0;
    logic [6:0] neuron_number = 7'h55;
    logic       mem_req;
    logic       mem_we;
    logic [9:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata = '0;
    logic       mem_ack = 1'b0;
    logic       o_wait;
    logic       upd_valid;
    logic [2:0] upd_idx;
    logic [7:0] updated_weight;
    logic       overrun;

    stdp_update_engine dut (
        .clk            (clk),
        .rst            (rst),
        .kill           (kill),
        .tick           (tick),
        .pre_spike      (pre_spike),
        .post_spike     (post_spike),
        .neuron_number  (neuron_number),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_ack        (mem_ack),
        .o_wait         (o_wait),
        .upd_valid      (upd_valid),
        .upd_idx        (upd_idx),
        .updated_weight (updated_weight),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // memory model controls and logs
    logic       mem_en = 1'b1;
    int         ack_delay = 0;
    logic [7:0] rd_val = '0;
    int         force_req = 0;
    int         force_done = 0;
    int         req_age = 0;
    logic [9:0] rd_addr_log = '0;
    logic [9:0] wr_addr_log = '0;
    logic [7:0] wr_data_log = '0;
    int         req_cyc = 0;
    int         owait_cyc = 0;
    int         upd_total = 0;
    int         unstable = 0;
    logic       prev_req = 1'b0;
    logic [9:0] prev_addr = '0;
    logic [7:0] prev_wdata = '0;
    logic       prev_we = 1'b0;
    int         owait_low = 0;

    always @(negedge clk) begin
        mem_rdata = rd_val;
        if (mem_req) req_cyc++;
        if (o_wait) owait_cyc++;
        if (upd_valid) upd_total++;
        if (mem_req && prev_req && (mem_addr != prev_addr || mem_we != prev_we || (mem_we && mem_wdata != prev_wdata)))
            unstable++;
        prev_req = mem_req; prev_addr = mem_addr; prev_we = mem_we; prev_wdata = mem_wdata;
        if (force_req != force_done) begin
            force_done = force_req;
            mem_ack = 1'b1;
        end else if (mem_ack) begin
            mem_ack = 1'b0;
            req_age = 0;
        end else if (mem_req && mem_en) begin
            if (req_age >= ack_delay) begin
                mem_ack = 1'b1;
                req_age = 0;
                if (mem_we) begin
                    wr_addr_log = mem_addr;
                    wr_data_log = mem_wdata;
                end else begin
                    rd_addr_log = mem_addr;
                end
            end else begin
                req_age++;
            end
        end else begin
            req_age = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_tick(input logic [7:0] pre, input logic post);
        tick = 1'b1; pre_spike = pre; post_spike = post;
        @(negedge clk);
        tick = 1'b0; pre_spike = '0; post_spike = 1'b0;
    endtask

    task automatic do_kill();
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
    endtask

    task automatic wait_upd(input string tag, output int cyc);
        cyc = 0;
        while (!upd_valid && cyc < 100) begin
            if (!o_wait) owait_low++;
            @(negedge clk);
            cyc++;
        end
        check({tag, "_upd_seen"}, 32'(upd_valid), 32'd1);
    endtask

    task automatic wait_req(input string tag);
        int c;
        c = 0;
        while (!mem_req && c < 50) begin
            if (!o_wait) owait_low++;
            @(negedge clk);
            c++;
        end
        check({tag, "_req_seen"}, 32'(mem_req), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int r0, w0, u0;

        repeat (3) @(negedge clk);
        check("rst_req", 32'(mem_req), 0);
        check("rst_we", 32'(mem_we), 0);
        check("rst_addr", 32'(mem_addr), 0);
        check("rst_wdata", 32'(mem_wdata), 0);
        check("rst_wait", 32'(o_wait), 0);
        check("rst_upd", 32'(upd_valid), 0);
        check("rst_overrun", 32'(overrun), 0);
        rst = 1'b1;
        @(negedge clk);

        // LTP dt=5, zero-wait memory: 100 + (16>>1) = 108, 5-cycle latency
        rd_val = 8'd100; ack_delay = 0;
        do_tick(8'h08, 1'b0);
        repeat (4) do_tick(8'h00, 1'b0);
        do_tick(8'h00, 1'b1);
        wait_upd("ltp", cyc);
        check("ltp_latency", 32'(cyc), 32'd5);
        check("ltp_idx", 32'(upd_idx), 32'd3);
        check("ltp_w", 32'(updated_weight), 32'd108);
        check("ltp_rd_addr", 32'(rd_addr_log), 32'h2AB);
        check("ltp_wr_addr", 32'(wr_addr_log), 32'h2AB);
        check("ltp_wdata", 32'(wr_data_log), 32'd108);
        @(negedge clk);
        check("ltp_upd_pulse", 32'(upd_valid), 0);
        check("ltp_idle", 32'(o_wait), 0);

        // LTD dt=2, 5 - 12 floors at 0
        do_kill();
        rd_val = 8'd5;
        do_tick(8'h00, 1'b1);
        do_tick(8'h00, 1'b0);
        do_tick(8'h04, 1'b0);
        wait_upd("ltd", cyc);
        check("ltd_idx", 32'(upd_idx), 32'd2);
        check("ltd_w", 32'(updated_weight), 32'd0);
        check("ltd_wr_addr", 32'(wr_addr_log), 32'h2AA);
        @(negedge clk);

        // window edge dt=15: 40 + (16>>3) = 42
        do_kill();
        rd_val = 8'd40;
        do_tick(8'h02, 1'b0);
        repeat (14) do_tick(8'h00, 1'b0);
        do_tick(8'h00, 1'b1);
        wait_upd("win15", cyc);
        check("win15_idx", 32'(upd_idx), 32'd1);
        check("win15_w", 32'(updated_weight), 32'd42);
        @(negedge clk);

        // dt=16 is outside the window: no request, never busy
        do_kill();
        r0 = req_cyc; w0 = owait_cyc;
        do_tick(8'h02, 1'b0);
        repeat (15) do_tick(8'h00, 1'b0);
        do_tick(8'h00, 1'b1);
        repeat (10) @(negedge clk);
        check("win16_req", 32'(req_cyc - r0), 0);
        check("win16_wait", 32'(owait_cyc - w0), 0);

        // same tick dt=0, 250 + 16 saturates at 255
        do_kill();
        rd_val = 8'd250;
        do_tick(8'h01, 1'b1);
        wait_upd("same", cyc);
        check("same_idx", 32'(upd_idx), 32'd0);
        check("same_w", 32'(updated_weight), 32'd255);
        @(negedge clk);

        // multi-synapse with delayed acks; second post while synapse 1 is
        // in service re-arms 1 and overwrites still-pending 6 (overrun).
        // Lowest-index-first gives service order 1, 1, 6.
        do_kill();
        check("multi_ovr_pre", 32'(overrun), 0);
        rd_val = 8'd50; ack_delay = 3;
        do_tick(8'h42, 1'b0);
        do_tick(8'h00, 1'b1);
        owait_low = 0;
        wait_req("multi");
        do_tick(8'h00, 1'b1);
        check("multi_overrun", 32'(overrun), 1);
        wait_upd("multi_a", cyc);
        check("multi_a_idx", 32'(upd_idx), 32'd1);
        check("multi_a_w", 32'(updated_weight), 32'd66);
        @(negedge clk);
        wait_upd("multi_b", cyc);
        check("multi_b_idx", 32'(upd_idx), 32'd1);
        @(negedge clk);
        wait_upd("multi_c", cyc);
        check("multi_c_idx", 32'(upd_idx), 32'd6);
        check("multi_c_w", 32'(updated_weight), 32'd66);
        check("multi_c_addr", 32'(wr_addr_log), 32'h2AE);
        check("multi_wait_held", 32'(owait_low), 0);
        @(negedge clk);
        check("multi_ovr_sticky", 32'(overrun), 1);

        // kill mid-read, stray ack afterwards, then a clean pairing
        do_kill();
        check("kill_ovr_clr", 32'(overrun), 0);
        mem_en = 1'b0; ack_delay = 0;
        do_tick(8'h10, 1'b0);
        do_tick(8'h00, 1'b1);
        wait_req("kill");
        check("kill_rd_we", 32'(mem_we), 0);
        u0 = upd_total;
        do_kill();
        check("kill_req", 32'(mem_req), 0);
        check("kill_wait", 32'(o_wait), 0);
        force_req++;
        repeat (5) @(negedge clk);
        check("kill_stray_req", 32'(mem_req), 0);
        check("kill_stray_upd", 32'(upd_total - u0), 0);
        check("kill_stray_wait", 32'(o_wait), 0);
        mem_en = 1'b1; rd_val = 8'd100;
        do_tick(8'h20, 1'b0);
        do_tick(8'h00, 1'b1);
        wait_upd("fresh", cyc);
        check("fresh_idx", 32'(upd_idx), 32'd5);
        check("fresh_w", 32'(updated_weight), 32'd116);
        @(negedge clk);

        // tick coincident with kill is dropped: pre[7] leaves no history
        kill = 1'b1; tick = 1'b1; pre_spike = 8'h80;
        @(negedge clk);
        kill = 1'b0; tick = 1'b0; pre_spike = '0;
        r0 = req_cyc; w0 = owait_cyc;
        do_tick(8'h00, 1'b1);
        repeat (8) @(negedge clk);
        check("killtick_req", 32'(req_cyc - r0), 0);
        check("killtick_wait", 32'(owait_cyc - w0), 0);

        check("req_stable", 32'(unstable), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/stdp_update_engine.md
Name: stdp_update_engine

Overview:
- Parametrised pair-based STDP engine for one physical neuron with N_PRE presynaptic inputs.
- Tracks per-synapse spike timing as saturating age counters and detects LTP (pre→post) and LTD (post→pre) pairings inside a window.
- Queues each pairing, looks up a shift-decay weight delta, and performs a saturating read-modify-write on the external synaptic weight memory through a req/ack handshake.
- Sits between the spike router and the weight SRAM.

Parameters:
- N_PRE, 8, presynaptic inputs per neuron; IDX_W = clog2(N_PRE)
- W_WIDTH, 8, unsigned weight width
- T_WIDTH, 5, age counter width; counters saturate at 2^T_WIDTH-1
- NID_W, 7, neuron_number width
- WIN, 15, max pairing distance in ticks, inclusive; WIN < 2^T_WIDTH-1
- A_PLUS, 16, LTP amplitude at dt=0
- A_MINUS, 12, LTD amplitude at dt=0
- TAU_LOG2, 2, decay: delta halves every 2^TAU_LOG2 ticks

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- kill  in  1  synchronous abort/flush, active-high
- tick  in  1  time-step strobe; spikes are sampled only when tick=1
- pre_spike  in  N_PRE  presynaptic spikes for this step
- post_spike  in  1  postsynaptic spike for this step
- neuron_number  in  NID_W  upper address bits
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1=write, 0=read
- mem_addr  out  NID_W+IDX_W  {neuron_number, idx}
- mem_wdata  out  W_WIDTH  write data
- mem_rdata  in  W_WIDTH  read data, valid with mem_ack on a read
- mem_ack  in  1  one-cycle completion pulse
- o_wait  out  1  1 while any pairing is pending or FSM not IDLE
- upd_valid  out  1  one-cycle pulse on write ack
- upd_idx  out  IDX_W  synapse updated
- updated_weight  out  W_WIDTH  new weight
- overrun  out  1  sticky; new pairing overwrote an unserviced one

Behaviour:
- Reset: all outputs 0; ages saturated (no history); pending bits 0; FSM IDLE.
- Timing, per tick: dt = number of ticks between the two spikes; same tick gives dt=0.
- Age update: age <= spike ? 0 : sat(age+1). Pairing uses the pre-update age+1 for the partner, or 0 if both spikes fall on the same tick.
- LTP: on a tick with post_spike=1, for each i with dt_i <= WIN, set ltp_pend[i] and capture dt[i]. This includes i with pre_spike[i]=1 on the same tick (dt=0).
- LTD: on a tick with pre_spike[i]=1 and post_spike=0, if the post dt <= WIN, set ltd_pend[i] and capture dt[i].
- Only one pending kind per synapse: a new event overwrites the kind and dt, and sets overrun if the bit was already set and not yet in service.
- A synapse in service captures new events into its pending bit. Service does not re-read the updated dt.
- Delta: sh = dt >> TAU_LOG2; dw = (sh >= W_WIDTH+8) ? 0 : A >> sh, with A=A_PLUS for LTP and A_MINUS for LTD. Computed in stdp_delta_lut.
- Weight math: W_WIDTH+1 bits; LTP saturates at 2^W_WIDTH-1, LTD saturates at 0.
- FSM states:
  - IDLE: go to SEL when any bit is pending.
  - SEL: pick the lowest pending index; clear its bit; latch kind and dt.
  - RD: mem_req=1, we=0; on ack, latch rdata.
  - CALC: 1 cycle; compute new weight.
  - WR: mem_req=1, we=1, wdata=new; on ack, pulse upd_valid, then go to SEL if more bits are pending, else IDLE.
- Latency, single event with 0-wait memory: upd_valid 5 cycles after the tick.
- mem_addr, we and wdata stay stable while mem_req is high. mem_ack while req=0 is ignored.
- kill:
  - Next edge: FSM to IDLE, mem_req=0, pending bits and overrun cleared, ages saturated.
  - An in-flight write is abandoned and upd_valid is not pulsed.
  - tick in the same cycle as kill is ignored.
- Reset mid-operation: same as kill, asynchronously.

Decomposition:
- Package stdp_pkg:
  - FSM state enum: IDLE, SEL, RD, CALC, WR
  - pairing kind enum: LTP, LTD
  - sat_add / sat_sub functions
  - default amplitude and window constants
- Sub-module stdp_delta_lut: combinational; (kind, dt) → dw, parametrised by A_PLUS, A_MINUS, TAU_LOG2, W_WIDTH.

Test Plan:
- LTP, zero-wait memory: pre_spike[3] at tick 0, post at tick 5, rdata=100 → read then write at addr {nid,3}, wdata=108 (dw = 16>>1 = 8); upd_valid with idx=3.
- LTD saturation: post at tick 0, pre_spike[2] at tick 2, rdata=5 → wdata=0 (dw=12).
- Window edge: pre[1] then post at dt=15 → dw = 16>>3 = 2, update occurs; repeat with dt=16 → no mem_req, o_wait stays 0.
- Same tick plus LTP ceiling: pre[0] and post on one tick, rdata=250 → dt=0, dw=16, wdata=255.
- Multi-synapse and overrun:
  - pre[6] and pre[1] at tick 0, post at tick 1, ack delayed 3 cycles → synapse 1 serviced then 6; o_wait high throughout.
  - A second post before synapse 6 is served → overrun=1.
- kill mid-RD: assert kill while mem_req=1, we=0 → next cycle mem_req=0, o_wait=0, no upd_valid; a later ack is ignored and a fresh pairing works normally.
